// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side bus of the I2C transaction arbiter: packed per-requester
// request fields in, per-requester ready/response pulses out.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqRw;
    logic [7*NREQ-1:0] reqDevAddr;
    logic [8*NREQ-1:0] reqInnerAddr;
    logic [8*NREQ-1:0] reqData;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ-1:0]   rspValid;
    logic [7:0]        rspData;
    logic              rspErr;

    modport master (
        output reqValid, reqRw, reqDevAddr, reqInnerAddr, reqData,
        input  reqReady, rspValid, rspData, rspErr
    );

    modport slave (
        input  reqValid, reqRw, reqDevAddr, reqInnerAddr, reqData,
        output reqReady, rspValid, rspData, rspErr
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C driver between NREQ requesters; holds
// the driver command stable for a whole transfer and returns data/status.
module i2c_txn_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 4
) (
    input  logic             clk,
    input  logic             rst,
    i2c_txn_arbiter_if.slave bus,
    output logic             busy,
    output logic             drvGo,
    output logic             drvRw,
    output logic [6:0]       drvDevAddr,
    output logic [7:0]       drvInnerAddr,
    output logic [7:0]       drvSendData,
    input  logic [7:0]       drvReadData,
    input  logic             drvDone
);
    localparam int          IW       = $clog2(NREQ);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, GRANT, RUN, GAP, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   ptr, gnt, pick, idx;
    logic [15:0]     cnt;
    logic            doneQ, doneEdge;
    logic [NREQ-1:0] reqReadyQ, rspValidQ;
    logic [7:0]      rspDataQ;
    logic            rspErrQ;

    logic [6:0] devArr  [NREQ];
    logic [7:0] innerArr[NREQ];
    logic [7:0] dataArr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign devArr[i]   = bus.reqDevAddr[7*i +: 7];
        assign innerArr[i] = bus.reqInnerAddr[8*i +: 8];
        assign dataArr[i]  = bus.reqData[8*i +: 8];
    end

    assign doneEdge     = drvDone & ~doneQ;
    assign bus.reqReady = reqReadyQ;
    assign bus.rspValid = rspValidQ;
    assign bus.rspData  = rspDataQ;
    assign bus.rspErr   = rspErrQ;

    // Walk downward so the candidate closest to ptr is the last one written.
    always_comb begin
        pick = ptr;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (bus.reqValid[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            cnt          <= '0;
            doneQ        <= 1'b0;
            reqReadyQ    <= '0;
            rspValidQ    <= '0;
            rspDataQ     <= '0;
            rspErrQ      <= 1'b0;
            busy         <= 1'b0;
            drvGo        <= 1'b0;
            drvRw        <= 1'b0;
            drvDevAddr   <= '0;
            drvInnerAddr <= '0;
            drvSendData  <= '0;
        end else begin
            // Edge history tracks every cycle so a level held from the
            // previous transfer never looks like a fresh completion.
            doneQ     <= drvDone;
            reqReadyQ <= '0;
            rspValidQ <= '0;
            case (state)
                IDLE: begin
                    if (|bus.reqValid) begin
                        gnt       <= pick;
                        reqReadyQ <= NREQ'(1) << pick;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    drvRw        <= bus.reqRw[gnt];
                    drvDevAddr   <= devArr[gnt];
                    drvInnerAddr <= innerArr[gnt];
                    drvSendData  <= dataArr[gnt];
                    ptr          <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                    cnt          <= '0;
                    drvGo        <= 1'b1;
                    state        <= RUN;
                end
                RUN: begin
                    if (doneEdge) begin
                        rspDataQ <= drvRw ? drvReadData : 8'h00;
                        rspErrQ  <= 1'b0;
                        drvGo    <= 1'b0;
                        cnt      <= '0;
                        state    <= GAP;
                    end else if (cnt == TO_LAST) begin
                        rspDataQ <= 8'h00;
                        rspErrQ  <= 1'b1;
                        drvGo    <= 1'b0;
                        cnt      <= '0;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        rspValidQ <= NREQ'(1) << gnt;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    drvGo <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
